// File: rtl/mips_multicycle_control_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control_if
// Bundles the instruction/flag inputs and all datapath control outputs of the
// multicycle MIPS controller.
//   master : the controller (samples Opcode/Funct/ALU flags, drives controls)
//   slave  : the datapath side (drives Opcode/Funct/ALU flags, samples controls)
// -----------------------------------------------------------------------------
interface mips_multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       ALU_zero;
    logic       ALU_overflow;

    logic       Dp_reset;
    logic       PC_load;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       wr;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       A_load;
    logic       B_load;
    logic       MDR_load;
    logic       ALUOut_load;
    logic       EPC_load;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [2:0] ALU_sel;
    logic       Cause;
    logic [3:0] State;

    modport master (
        input  Opcode, Funct, ALU_zero, ALU_overflow,
        output Dp_reset, PC_load, PCWrite, PCWriteCond, IorD, wr, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, A_load, B_load, MDR_load,
               ALUOut_load, EPC_load, PCSource, ALUSrcB, ALU_sel, Cause, State
    );

    modport slave (
        output Opcode, Funct, ALU_zero, ALU_overflow,
        input  Dp_reset, PC_load, PCWrite, PCWriteCond, IorD, wr, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, A_load, B_load, MDR_load,
               ALUOut_load, EPC_load, PCSource, ALUSrcB, ALU_sel, Cause, State
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
// Moore control FSM for the multicycle MIPS datapath (add/sub/and/xor, addi,
// lw, sw, beq, bne, j). Invalid opcodes/functs and signed overflow divert
// into an exception sequence that saves EPC and loads the exception vector.
// Ports:
//   Clk    : system clock, rising edge
//   Reset  : asynchronous active-high reset, forces RESET
//   bus    : master modport of mips_multicycle_control_if (IR fields, ALU
//            flags in; datapath controls, Cause and State out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET      | clear datapath registers (Dp_reset)
// FETCH      | memory read at PC
// FETCH_WAIT | load IR, PC <- PC + 4
// DECODE     | load A/B, ALUOut <- branch target, dispatch on opcode
// MEM_ADDR   | ALUOut <- A + sign-extended imm
// MEM_READ   | memory read at ALUOut
// MEM_WAIT   | load MDR
// MEM_WB     | rt <- MDR
// MEM_WRITE  | memory write at ALUOut
// R_EXEC     | ALUOut <- A op B
// R_WB       | rd <- ALUOut
// ADDI_EXEC  | ALUOut <- A + sign-extended imm
// ADDI_WB    | rt <- ALUOut
// BRANCH     | compare A - B, conditional PC <- ALUOut
// JUMP       | PC <- jump target
// EXCEPTION  | EPC <- PC - 4, PC <- exception vector
// -----------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
    input  logic                        Clk,
    input  logic                        Reset,
    mips_multicycle_control_if.master   bus
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_MEM_ADDR   = 4'd4,
        S_MEM_READ   = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_MEM_WB     = 4'd7,
        S_MEM_WRITE  = 4'd8,
        S_R_EXEC     = 4'd9,
        S_R_WB       = 4'd10,
        S_ADDI_EXEC  = 4'd11,
        S_ADDI_WB    = 4'd12,
        S_BRANCH     = 4'd13,
        S_JUMP       = 4'd14,
        S_EXCEPTION  = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    state_t state_q, state_d;
    logic   cause_q, cause_d;

    logic       dp_reset, pc_write, pc_write_cond, iord, wr, mem_to_reg, ir_write;
    logic       alu_src_a, reg_write, reg_dst, a_load, b_load, mdr_load;
    logic       aluout_load, epc_load;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_sel;

    logic funct_valid;
    logic funct_arith;
    logic is_bne;

    assign funct_valid = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB) ||
                         (bus.Funct == FN_AND) || (bus.Funct == FN_XOR);
    // Only add/sub trap on overflow; logical ops never do.
    assign funct_arith = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB);
    assign is_bne      = (bus.Opcode == OP_BNE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RESET;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        dp_reset      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        wr            = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        a_load        = 1'b0;
        b_load        = 1'b0;
        mdr_load      = 1'b0;
        aluout_load   = 1'b0;
        epc_load      = 1'b0;
        pc_source     = 2'b00;
        alu_src_b     = 2'b00;
        alu_sel       = 3'b000;

        case (state_q)
            S_RESET: begin
                dp_reset = 1'b1;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_sel   = ALU_ADD;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                a_load      = 1'b1;
                b_load      = 1'b1;
                alu_src_b   = 2'b11;
                alu_sel     = ALU_ADD;
                aluout_load = 1'b1;
                case (bus.Opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_valid) begin
                            state_d = S_R_EXEC;
                        end else begin
                            state_d = S_EXCEPTION;
                            cause_d = 1'b0;
                        end
                    end
                    default: begin
                        state_d = S_EXCEPTION;
                        cause_d = 1'b0;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_sel     = ALU_ADD;
                aluout_load = 1'b1;
                state_d     = (bus.Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                iord    = 1'b1;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                iord     = 1'b1;
                mdr_load = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord    = 1'b1;
                wr      = 1'b1;
                state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a   = 1'b1;
                aluout_load = 1'b1;
                case (bus.Funct)
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_XOR:  alu_sel = ALU_XOR;
                    default: alu_sel = ALU_ADD;
                endcase
                if (bus.ALU_overflow && funct_arith) begin
                    state_d = S_EXCEPTION;
                    cause_d = 1'b1;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_sel     = ALU_ADD;
                aluout_load = 1'b1;
                if (bus.ALU_overflow) begin
                    state_d = S_EXCEPTION;
                    cause_d = 1'b1;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_sel       = ALU_SUB;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXCEPTION: begin
                // ALU computes PC-4 for EPC; the new PC comes from the vector mux input.
                alu_src_b = 2'b01;
                alu_sel   = ALU_SUB;
                epc_load  = 1'b1;
                pc_source = EXC_VECTOR_SEL;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign bus.Dp_reset    = dp_reset;
    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = iord;
    assign bus.wr          = wr;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.IRWrite     = ir_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.RegWrite    = reg_write;
    assign bus.RegDst      = reg_dst;
    assign bus.A_load      = a_load;
    assign bus.B_load      = b_load;
    assign bus.MDR_load    = mdr_load;
    assign bus.ALUOut_load = aluout_load;
    assign bus.EPC_load    = epc_load;
    assign bus.PCSource    = pc_source;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALU_sel     = alu_sel;
    assign bus.Cause       = cause_q;
    assign bus.State       = state_q;
    // bne inverts the zero test; PCWrite-driven loads are unconditional.
    assign bus.PC_load     = pc_write | (pc_write_cond & (bus.ALU_zero ^ is_bne));

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.EXC_VECTOR_SEL(2'b11)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Packed view of every registered-decode output.
    logic [21:0] act;
    assign act = {bus.Dp_reset, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.wr,
                  bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                  bus.A_load, bus.B_load, bus.MDR_load, bus.ALUOut_load, bus.EPC_load,
                  bus.PCSource, bus.ALUSrcB, bus.ALU_sel};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected control word for a state, straight from the per-state output list.
    function automatic logic [21:0] exp_outs(input int st, input logic [5:0] fn);
        logic [21:0] e;
        e = '0;
        case (st)
            0:  e[21] = 1'b1;
            2:  begin e[15] = 1'b1; e[20] = 1'b1; e[4:3] = 2'b01; e[2:0] = 3'b001; end
            3:  begin e[11] = 1'b1; e[10] = 1'b1; e[4:3] = 2'b11; e[2:0] = 3'b001; e[8] = 1'b1; end
            4:  begin e[14] = 1'b1; e[4:3] = 2'b10; e[2:0] = 3'b001; e[8] = 1'b1; end
            5:  e[18] = 1'b1;
            6:  begin e[18] = 1'b1; e[9] = 1'b1; end
            7:  begin e[16] = 1'b1; e[13] = 1'b1; end
            8:  begin e[18] = 1'b1; e[17] = 1'b1; end
            9:  begin
                    e[14] = 1'b1; e[8] = 1'b1;
                    e[2:0] = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 :
                             (fn == 6'h26) ? 3'b110 : 3'b001;
                end
            10: begin e[12] = 1'b1; e[13] = 1'b1; end
            11: begin e[14] = 1'b1; e[4:3] = 2'b10; e[2:0] = 3'b001; e[8] = 1'b1; end
            12: e[13] = 1'b1;
            13: begin e[14] = 1'b1; e[2:0] = 3'b010; e[6:5] = 2'b01; e[19] = 1'b1; end
            14: begin e[6:5] = 2'b10; e[20] = 1'b1; end
            15: begin e[4:3] = 2'b01; e[2:0] = 3'b010; e[7] = 1'b1; e[6:5] = 2'b11; e[20] = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Reference model: the list of states an instruction visits, plus the
    // cause it would record if it traps.
    int   path_q[$];
    logic exc_c;
    logic cause_m = 1'b0;

    function automatic void build_path(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
        logic r_ok, r_arith;
        r_ok    = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h26);
        r_arith = (fn == 6'h20) || (fn == 6'h22);
        path_q.delete();
        path_q.push_back(1); path_q.push_back(2); path_q.push_back(3);
        exc_c = 1'b0;
        case (op)
            6'h23: begin path_q.push_back(4); path_q.push_back(5); path_q.push_back(6); path_q.push_back(7); end
            6'h2B: begin path_q.push_back(4); path_q.push_back(8); end
            6'h00: begin
                if (!r_ok) path_q.push_back(15);
                else begin
                    path_q.push_back(9);
                    if (ovf && r_arith) begin path_q.push_back(15); exc_c = 1'b1; end
                    else path_q.push_back(10);
                end
            end
            6'h08: begin
                path_q.push_back(11);
                if (ovf) begin path_q.push_back(15); exc_c = 1'b1; end
                else path_q.push_back(12);
            end
            6'h04, 6'h05: path_q.push_back(13);
            6'h02:        path_q.push_back(14);
            default:      path_q.push_back(15);
        endcase
    endfunction

    // Runs one instruction from FETCH back to FETCH; zmode 0/1 holds ALU_zero, 2 randomizes it per cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input int zmode,
                             output int lat, output int rwc, output int wrc, output int pcl);
        int          st_e;
        logic        pl_e;
        logic [21:0] e;
        bit          done;
        build_path(op, fn, ovf);
        bus.Opcode       = op;
        bus.Funct        = fn;
        bus.ALU_overflow = ovf;
        bus.ALU_zero     = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        #1;
        lat = 0; rwc = 0; wrc = 0; pcl = 0; done = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0 && bus.State == 4'd1) begin
                done = 1;
                break;
            end
            st_e = (c < path_q.size()) ? path_q[c] : 1;
            if (st_e == 15) cause_m = exc_c;
            chk("state", 32'(bus.State), 32'(st_e));
            e = exp_outs(st_e, fn);
            chk("outputs", 32'(act), 32'(e));
            pl_e = e[20] | (e[19] & (bus.ALU_zero ^ (op == 6'h05)));
            chk("pc_load", 32'(bus.PC_load), 32'(pl_e));
            chk("cause", 32'(bus.Cause), 32'(cause_m));
            rwc += int'(bus.RegWrite);
            wrc += int'(bus.wr);
            pcl += int'(bus.PC_load);
            lat++;
            @(negedge Clk);
            if (zmode == 2) bus.ALU_zero = 1'($urandom_range(0, 1));
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no return to FETCH within 12 cycles, op %0h", op);
        end
        chk("latency", 32'(lat), 32'(path_q.size()));
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       ovf;
        int         z;
        int         lat;
        int         rw;
        int         wr;
        int         pcl;
        logic       cause;
    } vec_t;

    vec_t tbl[15];

    int rw_seen = 0;
    int wr_seen = 0;
    bit mon_en  = 0;
    always @(posedge bus.RegWrite) if (mon_en) rw_seen++;
    always @(posedge bus.wr)       if (mon_en) wr_seen++;

    initial begin
        int lat, rwc, wrc, pcl;
        logic [5:0] op, fn;
        logic [5:0] ops[8];

        tbl[0]  = '{6'h00, 6'h20, 1'b0, 0, 5, 1, 0, 1, 1'b0};  // add
        tbl[1]  = '{6'h00, 6'h22, 1'b1, 0, 5, 0, 0, 2, 1'b1};  // sub overflow
        tbl[2]  = '{6'h00, 6'h24, 1'b1, 0, 5, 1, 0, 1, 1'b1};  // and ignores overflow
        tbl[3]  = '{6'h00, 6'h26, 1'b0, 0, 5, 1, 0, 1, 1'b1};  // xor
        tbl[4]  = '{6'h00, 6'h21, 1'b0, 0, 4, 0, 0, 2, 1'b0};  // bad funct
        tbl[5]  = '{6'h08, 6'h00, 1'b0, 0, 5, 1, 0, 1, 1'b0};  // addi
        tbl[6]  = '{6'h08, 6'h00, 1'b1, 0, 5, 0, 0, 2, 1'b1};  // addi overflow
        tbl[7]  = '{6'h23, 6'h00, 1'b1, 0, 7, 1, 0, 1, 1'b1};  // lw ignores overflow
        tbl[8]  = '{6'h2B, 6'h00, 1'b0, 0, 5, 0, 1, 1, 1'b1};  // sw
        tbl[9]  = '{6'h04, 6'h00, 1'b0, 1, 4, 0, 0, 2, 1'b1};  // beq taken
        tbl[10] = '{6'h04, 6'h00, 1'b0, 0, 4, 0, 0, 1, 1'b1};  // beq not taken
        tbl[11] = '{6'h05, 6'h00, 1'b0, 1, 4, 0, 0, 1, 1'b1};  // bne not taken
        tbl[12] = '{6'h05, 6'h00, 1'b0, 0, 4, 0, 0, 2, 1'b1};  // bne taken
        tbl[13] = '{6'h02, 6'h00, 1'b0, 0, 4, 0, 0, 2, 1'b1};  // j
        tbl[14] = '{6'h3F, 6'h00, 1'b0, 0, 4, 0, 0, 2, 1'b0};  // invalid opcode

        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};

        bus.Opcode = 6'h00; bus.Funct = 6'h00; bus.ALU_zero = 1'b0; bus.ALU_overflow = 1'b0;

        // Power-on reset: outputs asserted before any clock edge.
        #2;
        chk("reset_state", 32'(bus.State), 32'd0);
        chk("reset_outs", 32'(act), 32'(exp_outs(0, 6'h00)));
        chk("reset_cause", 32'(bus.Cause), 32'd0);
        chk("reset_pc_load", 32'(bus.PC_load), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("release_hold", 32'(bus.State), 32'd0);
        @(negedge Clk); #1;
        chk("first_fetch", 32'(bus.State), 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].ovf, tbl[i].z, lat, rwc, wrc, pcl);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_regwrite", i), 32'(rwc), 32'(tbl[i].rw));
            chk($sformatf("tbl%0d_wr", i), 32'(wrc), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_pc_load", i), 32'(pcl), 32'(tbl[i].pcl));
            chk($sformatf("tbl%0d_cause", i), 32'(bus.Cause), 32'(tbl[i].cause));
        end

        for (int i = 0; i < 80; i++) begin
            int k;
            k  = $urandom_range(0, 8);
            op = (k == 8) ? 6'($urandom) : ops[k];
            case ($urandom_range(0, 4))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h26;
                default: fn = 6'($urandom);
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), 2, lat, rwc, wrc, pcl);
        end

        // Put Cause at 1 so the reset clearing it is observable.
        run_instr(6'h08, 6'h00, 1'b1, 0, lat, rwc, wrc, pcl);
        chk("pre_reset_cause", 32'(bus.Cause), 32'd1);

        // lw interrupted by reset while in MEM_WAIT.
        bus.Opcode = 6'h23; bus.Funct = 6'h00; bus.ALU_overflow = 1'b0; bus.ALU_zero = 1'b0;
        repeat (5) @(negedge Clk);
        #1;
        chk("mid_lw_state", 32'(bus.State), 32'd6);
        mon_en = 1;
        #2;
        Reset = 1'b1;
        #1;
        cause_m = 1'b0;
        chk("async_reset_state", 32'(bus.State), 32'd0);
        chk("async_reset_outs", 32'(act), 32'(exp_outs(0, 6'h00)));
        chk("async_reset_cause", 32'(bus.Cause), 32'd0);
        @(negedge Clk); #1;
        chk("reset_held_state", 32'(bus.State), 32'd0);
        Reset = 1'b0;
        #1;
        chk("post_release_state", 32'(bus.State), 32'd0);
        @(negedge Clk); #1;
        chk("post_release_fetch", 32'(bus.State), 32'd1);
        mon_en = 0;
        chk("aborted_regwrite", 32'(rw_seen), 32'd0);
        chk("aborted_wr", 32'(wr_seen), 32'd0);

        run_instr(6'h00, 6'h20, 1'b0, 0, lat, rwc, wrc, pcl);
        chk("post_reset_add_regwrite", 32'(rwc), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
